// File: rtl/result_axis_serializer.sv
// Serializes one wide result frame into ELEMS sequential AXI-Stream beats,
// lowest element first, with zero-bubble chaining of back-to-back frames.

module result_elem_lane #(
  parameter int ELEM_W = 16
) (
  input  logic              axi_clk,
  input  logic              axi_rst,
  input  logic              load,
  input  logic [ELEM_W-1:0] d,
  output logic [ELEM_W-1:0] q
);
  always_ff @(posedge axi_clk) begin
    if (axi_rst)   q <= '0;
    else if (load) q <= d;
  end
endmodule

module result_axis_serializer #(
  parameter int ELEMS  = 9,
  parameter int ELEM_W = 16
) (
  input  logic                    axi_clk,
  input  logic                    axi_rst,
  input  logic                    s_axis_valid,
  input  logic [ELEMS*ELEM_W-1:0] s_axis_data,
  output logic                    s_axis_ready,
  output logic                    m_axis_valid,
  output logic [ELEM_W-1:0]       m_axis_data,
  output logic                    m_axis_last,
  input  logic                    m_axis_ready,
  output logic                    busy,
  output logic [15:0]             frame_count
);
  localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [15:0]                    cnt_q, cnt_d;
  logic [ELEMS-1:0][ELEM_W-1:0]   frame_q;
  logic                           load, out_xfer, last_xfer;

  // Buffer only loads on an accepted frame, so it is frozen mid-frame.
  for (genvar g = 0; g < ELEMS; g++) begin : g_lane
    result_elem_lane #(.ELEM_W(ELEM_W)) u_lane (
      .axi_clk (axi_clk),
      .axi_rst (axi_rst),
      .load    (load),
      .d       (s_axis_data[g*ELEM_W +: ELEM_W]),
      .q       (frame_q[g])
    );
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    m_axis_valid = (state_q == SHIFT);
    m_axis_last  = m_axis_valid && (idx_q == LAST_IDX);
    m_axis_data  = m_axis_valid ? frame_q[idx_q] : '0;
    busy         = (state_q == SHIFT);
    out_xfer     = m_axis_valid & m_axis_ready;
    last_xfer    = out_xfer & m_axis_last;
    // Ready on the final beat lets the next frame chain in without a bubble.
    s_axis_ready = (state_q == IDLE) | last_xfer;
    load         = s_axis_valid & s_axis_ready;

    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
          idx_d   = '0;
        end
      end
      SHIFT: begin
        if (last_xfer) begin
          cnt_d   = cnt_q + 16'd1;
          idx_d   = '0;
          state_d = load ? SHIFT : IDLE;
        end else if (out_xfer) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_count = cnt_q;

endmodule

// File: tb/tb_result_axis_serializer.sv
// Randomized and directed bench for result_axis_serializer against a queue-based model.

module tb_result_axis_serializer;
  localparam int N = 9;

  logic          axi_clk;
  logic          axi_rst;
  logic          s_axis_valid;
  logic [N*16-1:0] s_axis_data;
  logic          s_axis_ready;
  logic          m_axis_valid;
  logic [15:0]   m_axis_data;
  logic          m_axis_last;
  logic          m_axis_ready;
  logic          busy;
  logic [15:0]   frame_count;

  logic          w_rst, w_sv, w_sr, w_mv, w_ml, w_mr, w_busy;
  logic [15:0]   w_sd, w_md, w_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] mq[$];
  logic [15:0] exp_cnt = 16'h0;

  result_axis_serializer #(.ELEMS(N), .ELEM_W(16)) dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_ready(s_axis_ready),
    .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data), .m_axis_last(m_axis_last),
    .m_axis_ready(m_axis_ready), .busy(busy), .frame_count(frame_count)
  );

  // Single-element instance makes the 16-bit frame counter wrap reachable quickly.
  result_axis_serializer #(.ELEMS(1), .ELEM_W(16)) dut_w (
    .axi_clk(axi_clk), .axi_rst(w_rst),
    .s_axis_valid(w_sv), .s_axis_data(w_sd), .s_axis_ready(w_sr),
    .m_axis_valid(w_mv), .m_axis_data(w_md), .m_axis_last(w_ml),
    .m_axis_ready(w_mr), .busy(w_busy), .frame_count(w_cnt)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  function automatic logic [N*16-1:0] frame(input int base);
    logic [N*16-1:0] d;
    for (int k = 0; k < N; k++) d[k*16 +: 16] = 16'(base + k);
    return d;
  endfunction

  function automatic logic [N*16-1:0] rnd_frame();
    logic [N*16-1:0] d;
    for (int k = 0; k < N; k++) d[k*16 +: 16] = 16'($urandom);
    return d;
  endfunction

  // {busy, valid, last, s_ready, data, frame_count}
  function automatic logic [35:0] obs();
    return {busy, m_axis_valid, m_axis_last, s_axis_ready, m_axis_data, frame_count};
  endfunction

  function automatic logic [35:0] exp_vec();
    logic v, l, r;
    v = (mq.size() != 0);
    l = (mq.size() == 1);
    r = !v || (l && m_axis_ready === 1'b1);
    return {v, v, l, r, (v ? mq[0] : 16'h0), exp_cnt};
  endfunction

  // Model: queue of pending elements; a frame enters when the queue is empty
  // or its last element leaves on this edge.
  task automatic tick();
    bit acc;
    acc = (s_axis_valid === 1'b1) &&
          (mq.size() == 0 || (mq.size() == 1 && m_axis_ready === 1'b1));
    @(posedge axi_clk);
    if (axi_rst) begin
      mq.delete();
      exp_cnt = 16'h0;
    end else begin
      if (mq.size() != 0 && m_axis_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) exp_cnt++;
      end
      if (acc) for (int k = 0; k < N; k++) mq.push_back(s_axis_data[k*16 +: 16]);
    end
    #1;
  endtask

  task automatic do_reset();
    axi_rst = 1'b1; s_axis_valid = 1'b0; m_axis_ready = 1'b0;
    @(negedge axi_clk);
    tick();
    axi_rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      axi_rst = 1'b1; s_axis_valid = 1'b1; s_axis_data = rnd_frame(); m_axis_ready = 1'b1;
      @(negedge axi_clk);
      tick();
    end
    axi_rst = 1'b0; s_axis_valid = 1'b0; m_axis_ready = 1'b0;
    @(negedge axi_clk);
    checks++;
    if (obs() !== 36'h1_0000_0000) begin
      errors++; $display("FAIL reset_state got %h exp %h", obs(), 36'h1_0000_0000);
    end
    checks++;
    if (obs() !== exp_vec()) begin
      errors++; $display("FAIL reset_model got %h exp %h", obs(), exp_vec());
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      s_axis_valid = (c == 0); s_axis_data = frame(1); m_axis_ready = 1'b1;
      @(negedge axi_clk);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL single_frame cyc %0d got %h exp %h", c, obs(), exp_vec());
      end
      tick();
    end
    checks++;
    if (frame_count !== 16'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_count got cnt %0d busy %b exp cnt 1 busy 0", frame_count, busy);
    end
  endtask

  task automatic test_back_to_back();
    int sent, first, lastv, nvalid;
    logic [35:0] e;
    do_reset();
    sent = 0; first = -1; lastv = -1; nvalid = 0;
    for (int c = 0; c < 24; c++) begin
      s_axis_valid = (sent < 2); s_axis_data = frame(1 + 9*sent); m_axis_ready = 1'b1;
      @(negedge axi_clk);
      e = exp_vec();
      checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL back_to_back cyc %0d got %h exp %h", c, obs(), e);
      end
      if (m_axis_valid === 1'b1) begin
        nvalid++;
        if (first < 0) first = c;
        lastv = c;
      end
      if (s_axis_valid && e[32]) sent++;
      tick();
    end
    checks++;
    if (nvalid != 18 || (lastv - first) != 17) begin
      errors++; $display("FAIL b2b_contiguous got %0d valid over span %0d exp 18 over 18", nvalid, lastv - first + 1);
    end
    checks++;
    if (frame_count !== 16'd2) begin
      errors++; $display("FAIL b2b_count got %0d exp 2", frame_count);
    end
  endtask

  task automatic test_backpressure();
    int held;
    bit stall;
    do_reset();
    held = 0;
    for (int c = 0; c < 20; c++) begin
      stall = (mq.size() != 0) && (mq[0] == 16'd4) && (held < 3);
      m_axis_ready = !stall;
      s_axis_valid = (c == 0) || stall;
      s_axis_data  = (c == 0) ? frame(1) : rnd_frame();
      @(negedge axi_clk);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL backpressure cyc %0d got %h exp %h", c, obs(), exp_vec());
      end
      if (stall) begin
        checks++;
        if (m_axis_data !== 16'd4 || s_axis_ready !== 1'b0) begin
          errors++; $display("FAIL bp_hold got data %0d ready %b exp data 4 ready 0", m_axis_data, s_axis_ready);
        end
        held++;
      end
      tick();
    end
    checks++;
    if (frame_count !== 16'd1 || m_axis_valid !== 1'b0) begin
      errors++; $display("FAIL bp_count got cnt %0d valid %b exp cnt 1 valid 0", frame_count, m_axis_valid);
    end
  endtask

  task automatic test_busy_reject();
    bit pulse;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      pulse = (mq.size() != 0) && (mq[0] == 16'd5);
      s_axis_valid = (c == 0) || pulse;
      s_axis_data  = (c == 0) ? frame(1) : frame(100);
      m_axis_ready = 1'b1;
      @(negedge axi_clk);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL busy_reject cyc %0d got %h exp %h", c, obs(), exp_vec());
      end
      if (pulse) begin
        checks++;
        if (s_axis_ready !== 1'b0 || m_axis_data !== 16'd5) begin
          errors++; $display("FAIL reject_ready got ready %b data %0d exp ready 0 data 5", s_axis_ready, m_axis_data);
        end
      end
      tick();
    end
    checks++;
    if (frame_count !== 16'd1 || m_axis_valid !== 1'b0) begin
      errors++; $display("FAIL reject_count got cnt %0d valid %b exp cnt 1 valid 0", frame_count, m_axis_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit done, just_rst;
    int first_data;
    do_reset();
    done = 0; just_rst = 0;
    for (int c = 0; c < 10; c++) begin
      axi_rst = 1'b0;
      s_axis_valid = (c == 0); s_axis_data = frame(1); m_axis_ready = 1'b1;
      if (!done && mq.size() != 0 && mq[0] == 16'd4) begin
        axi_rst = 1'b1; s_axis_valid = 1'b1; s_axis_data = frame(50);
      end
      @(negedge axi_clk);
      if (just_rst) begin
        checks++;
        if (m_axis_valid !== 1'b0 || frame_count !== 16'd0 || s_axis_ready !== 1'b1 || m_axis_last !== 1'b0) begin
          errors++; $display("FAIL mid_reset got valid %b cnt %0d ready %b exp valid 0 cnt 0 ready 1",
                              m_axis_valid, frame_count, s_axis_ready);
        end
        just_rst = 0;
      end
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL reset_mid cyc %0d got %h exp %h", c, obs(), exp_vec());
      end
      if (axi_rst) begin done = 1; just_rst = 1; end
      tick();
    end
    axi_rst = 1'b0;
    first_data = -1;
    for (int c = 0; c < 12; c++) begin
      s_axis_valid = (c == 0); s_axis_data = frame(20); m_axis_ready = 1'b1;
      @(negedge axi_clk);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL after_reset cyc %0d got %h exp %h", c, obs(), exp_vec());
      end
      if (first_data < 0 && m_axis_valid === 1'b1) first_data = int'(m_axis_data);
      tick();
    end
    checks++;
    if (first_data != 20 || frame_count !== 16'd1) begin
      errors++; $display("FAIL after_reset_first got %0d cnt %0d exp 20 cnt 1", first_data, frame_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      axi_rst      = ($urandom_range(63) == 0);
      s_axis_valid = $urandom_range(1);
      s_axis_data  = rnd_frame();
      m_axis_ready = ($urandom_range(3) != 0);
      @(negedge axi_clk);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d got %h exp %h", c, obs(), exp_vec());
      end
      tick();
    end
    axi_rst = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] ed;
    s_axis_valid = 1'b0; m_axis_ready = 1'b0;
    w_rst = 1'b1; w_sv = 1'b0; w_mr = 1'b0; w_sd = 16'h0;
    @(posedge axi_clk); #1;
    w_rst = 1'b0; w_sv = 1'b1; w_mr = 1'b1;
    // Edge 1 accepts; every later edge completes one frame and accepts the next.
    for (int k = 1; k <= 65536; k++) begin
      w_sd = 16'(k*5 + 3);
      @(posedge axi_clk); #1;
    end
    ed = 16'(65536*5 + 3);
    @(negedge axi_clk);
    checks++;
    if (w_cnt !== 16'hFFFF || w_mv !== 1'b1 || w_ml !== 1'b1 || w_md !== ed) begin
      errors++; $display("FAIL wrap_pre got cnt %h valid %b last %b data %h exp cnt ffff valid 1 last 1 data %h",
                          w_cnt, w_mv, w_ml, w_md, ed);
    end
    w_sv = 1'b0;
    @(posedge axi_clk); #1;
    checks++;
    if (w_cnt !== 16'h0000 || w_mv !== 1'b0 || w_busy !== 1'b0) begin
      errors++; $display("FAIL wrap_post got cnt %h valid %b busy %b exp cnt 0000 valid 0 busy 0",
                          w_cnt, w_mv, w_busy);
    end
  endtask

  initial begin
    axi_rst = 1'b1; s_axis_valid = 1'b0; s_axis_data = '0; m_axis_ready = 1'b0;
    w_rst = 1'b1; w_sv = 1'b0; w_sd = 16'h0; w_mr = 1'b0;
    #1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_busy_reject();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_axis_serializer.md
RESULT_AXIS_SERIALIZER -- requirements
Module: result_axis_serializer

Interface
REQ-001 Parameter ELEMS, default 9: number of result elements per input frame.
REQ-002 Parameter ELEM_W, default 16: width of each result element in bits.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Port axi_clk  input  1: sole clock; all state SHALL update on its rising edge.
REQ-005 Port axi_rst  input  1: synchronous, active-high reset.
REQ-006 Port s_axis_valid  input  1: upstream frame valid.
REQ-007 Port s_axis_data  input  ELEMS*ELEM_W (144): packed frame; element k is in bits [k*ELEM_W +: ELEM_W].
REQ-008 Port s_axis_ready  output  1: block accepts a frame this cycle.
REQ-009 Port m_axis_valid  output  1: output element valid.
REQ-010 Port m_axis_data  output  ELEM_W (16): current element.
REQ-011 Port m_axis_last  output  1: marks the final element (k = ELEMS-1) of a frame.
REQ-012 Port m_axis_ready  input  1: downstream accepts the element.
REQ-013 Port busy  output  1: high while a frame is held (state SHIFT).
REQ-014 Port frame_count  output  16: count of frames fully emitted since reset.

Function
REQ-015 The block SHALL implement a two-state FSM, IDLE and SHIFT, with an ELEMS-wide frame buffer and element index idx (ceil(log2(ELEMS)) bits).
REQ-016 Input handshake: a frame is accepted on a rising edge where s_axis_valid & s_axis_ready; the buffer captures s_axis_data, idx <= 0, state <= SHIFT.
REQ-017 s_axis_ready SHALL be combinational: (state==IDLE) | (m_axis_valid & m_axis_last & m_axis_ready).
REQ-018 In SHIFT: m_axis_valid = 1, m_axis_data = buffer element idx, m_axis_last = (idx == ELEMS-1); in IDLE all three SHALL be 0.
REQ-019 Output handshake: on an edge with m_axis_valid & m_axis_ready and idx < ELEMS-1, idx <= idx+1.
REQ-020 On an edge with the last element transferred: frame_count <= frame_count+1; if s_axis_valid also high, the new frame is captured (REQ-016) and state stays SHIFT; otherwise state <= IDLE, idx <= 0.
REQ-021 Latency: first element is valid the cycle after frame acceptance; with m_axis_ready held high, one element per cycle, ELEMS cycles per frame, and zero bubble cycles between back-to-back frames.
REQ-022 Backpressure: while m_axis_valid & !m_axis_ready, m_axis_data, m_axis_last and idx SHALL hold stable.
REQ-023 Elements SHALL be emitted in ascending index order, element 0 (bits [15:0]) first; data SHALL pass unmodified.
REQ-024 s_axis_data is ignored in any cycle where s_axis_ready is 0; the buffer SHALL NOT change mid-frame.
REQ-025 frame_count SHALL wrap 0xFFFF -> 0x0000 without side effects.
REQ-026 busy SHALL equal (state == SHIFT).

Reset
REQ-027 On an edge with axi_rst = 1: state <= IDLE, idx <= 0, buffer <= 0, frame_count <= 0; hence m_axis_valid = 0, m_axis_last = 0, m_axis_data = 0, busy = 0, s_axis_ready = 1 the following cycle.
REQ-028 Reset mid-frame SHALL discard remaining elements without asserting m_axis_last, and frame_count SHALL NOT increment.
REQ-029 Reset SHALL take priority over every simultaneous handshake.

Verification
REQ-030 Single frame: elements 1..9 packed, m_axis_ready = 1 -> outputs 1,2,...,9 on 9 consecutive cycles starting one cycle after acceptance; m_axis_last only on 9; frame_count = 1; busy falls after element 9.
REQ-031 Back-to-back: frames {1..9} then {10..18} with s_axis_valid held and m_axis_ready = 1 -> 18 contiguous valid cycles; second frame accepted on the same edge as element 9; frame_count = 2.
REQ-032 Backpressure: m_axis_ready low for 3 cycles while element 4 (value 4) is presented -> m_axis_data stays 4, idx frozen; s_axis_ready = 0 throughout; emission resumes at 5 afterwards.
REQ-033 Ready-while-busy: second s_axis_valid pulse arriving during element 5 -> not accepted (s_axis_ready = 0), first frame output unaffected.
REQ-034 Reset mid-frame: axi_rst pulsed after element 3 -> next cycle m_axis_valid = 0, frame_count = 0, s_axis_ready = 1; next frame {20..28} emits from 20.
REQ-035 Wrap: frame_count forced to 0xFFFF via 65535 frames (or accelerated run) -> one more frame yields 0x0000.
